instr_fetch_unit: RTL and testbench

- Front end of the 32-bit processor.
- Owns the 8-bit program counter and drives the RAM fetch port (`fetch_address`/`fetch_out`).
- Captures each returned word into an instruction register and hands it to the decode/execute datapath with a valid/ready handshake.
- Handles stalls while the data port is busy, plus branch redirects that flush any fetch in flight.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the program counter, issues one-word
// fetches to the RAM fetch port, captures the returned word into the
// instruction register and offers it downstream with a valid/ready handshake.
// Branch redirects flush whatever fetch is in flight. Data-port stalls
// (mem_busy) hold off new requests.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    output logic               fetch_en,
    output logic [ADDR_W-1:0]  fetch_address,
    input  logic [INSTR_W-1:0] fetch_out,
    input  logic               mem_busy,
    input  logic               branch_valid,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_nxt;
    logic              capture;

    // State and program counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Instruction register: loaded only when a RESP completes without a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (capture) begin
            instr    <= fetch_out;
            instr_pc <= pc;
        end
    end

    // Next-state, next-pc and capture decode; a redirect overrides everything but reset
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                // The request goes out this cycle only if the data port is free
                if (!mem_busy) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // RAM data is valid now; mem_busy cannot cancel an in-flight response
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                // Advance only once downstream has taken the held word
                if (instr_ready) begin
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Redirect: drop the held word or the in-flight fetch and restart at the target
        if (branch_valid) begin
            pc_nxt    = branch_target;
            state_nxt = REQ;
            capture   = 1'b0;
        end
    end

    // Outputs decoded from the state register; only fetch_en looks at an input
    always_comb begin
        fetch_en      = (state == REQ) && !mem_busy;
        instr_valid   = (state == HOLD);
        fetch_address = {{(ADDR_W - PC_W){1'b0}}, pc};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios for reset, streaming,
// backpressure, stalls, branch redirects, pc wrap and mid-fetch reset,
// followed by randomized traffic checked against a transaction-level model
// (expected pc of the next delivered word, word must equal RAM[pc]).
module tb_instr_fetch_unit;

    localparam int PC_W    = 8;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               fetch_en;
    logic [ADDR_W-1:0]  fetch_address;
    logic [INSTR_W-1:0] fetch_out;
    logic               mem_busy;
    logic               branch_valid;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    logic [INSTR_W-1:0] mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .PC_W    (PC_W),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RESET_PC(8'h00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .fetch_address(fetch_address),
        .fetch_out    (fetch_out),
        .mem_busy     (mem_busy),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready)
    );

    // Synchronous-read RAM: data appears the cycle after fetch_en
    always @(posedge clk) begin
        if (fetch_en) fetch_out <= mem[fetch_address[PC_W-1:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Advance edge by edge until instr_valid is seen; edges = -1 on timeout
    task automatic wait_valid(output int edges);
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            smp();
            if (instr_valid) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0001 + 32'(i);
        rst = 1'b1; mem_busy = 1'b0; branch_valid = 1'b0;
        branch_target = '0; instr_ready = 1'b0;
        cyc(); cyc(); smp();
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        tests++; if (fetch_en !== 1'b0) begin fails++; $display("FAIL reset_fetch_en: got %b want 0", fetch_en); end
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instr); end
        tests++; if (instr_pc !== 8'h00) begin fails++; $display("FAIL reset_instr_pc: got %h want 00", instr_pc); end
        tests++; if (fetch_address !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h want 0000", fetch_address); end
    endtask

    task automatic test_streaming();
        int e;
        instr_ready = 1'b1;
        rst = 1'b0;
        wait_valid(e);
        tests++; if (e !== 3) begin fails++; $display("FAIL stream_first_latency: got %0d edges want 3", e); end
        tests++; if (instr !== 32'hA000_0001 || instr_pc !== 8'h00) begin
            fails++; $display("FAIL stream_first: got %h@%h want a0000001@00", instr, instr_pc); end
        for (int k = 1; k <= 3; k++) begin
            wait_valid(e);
            tests++; if (e !== 3 || instr_pc !== 8'(k) || instr !== 32'hA000_0001 + 32'(k)) begin
                fails++; $display("FAIL stream_%0d: got %h@%h gap %0d want %h@%h gap 3",
                                  k, instr, instr_pc, e, 32'hA000_0001 + 32'(k), 8'(k)); end
        end
    endtask

    task automatic test_backpressure();
        logic [INSTR_W-1:0] i0;
        logic [PC_W-1:0]    p0;
        int e;
        i0 = instr; p0 = instr_pc;
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(); smp();
            tests++; if (instr_valid !== 1'b1 || instr !== i0 || instr_pc !== p0 || fetch_en !== 1'b0) begin
                fails++; $display("FAIL bp_hold_%0d: got v%b %h@%h fe%b want v1 %h@%h fe0",
                                  k, instr_valid, instr, instr_pc, fetch_en, i0, p0); end
        end
        instr_ready = 1'b1;
        cyc(); smp();
        tests++; if (fetch_address !== {8'h00, p0 + 8'd1} || fetch_en !== 1'b1) begin
            fails++; $display("FAIL bp_release_fetch: got %h fe%b want %h fe1", fetch_address, fetch_en, {8'h00, p0 + 8'd1}); end
        wait_valid(e);
        tests++; if (e !== 2 || instr_pc !== p0 + 8'd1) begin
            fails++; $display("FAIL bp_next: got pc %h after %0d want pc %h after 2", instr_pc, e, p0 + 8'd1); end
    endtask

    task automatic test_stall();
        logic [PC_W-1:0] p;
        int e;
        p = instr_pc + 8'd1;
        cyc();
        mem_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            tests++; if (fetch_en !== 1'b0 || fetch_address !== {8'h00, p}) begin
                fails++; $display("FAIL stall_%0d: got fe%b addr %h want fe0 addr %h", k, fetch_en, fetch_address, {8'h00, p}); end
            cyc();
        end
        mem_busy = 1'b0;
        #1;
        tests++; if (fetch_en !== 1'b1 || fetch_address !== {8'h00, p}) begin
            fails++; $display("FAIL stall_release: got fe%b addr %h want fe1 addr %h", fetch_en, fetch_address, {8'h00, p}); end
        smp();
        wait_valid(e);
        tests++; if (e !== 2 || instr_pc !== p || instr !== mem[p]) begin
            fails++; $display("FAIL stall_result: got %h@%h after %0d want %h@%h after 2", instr, instr_pc, e, mem[p], p); end
    endtask

    task automatic test_branch_resp();
        int e;
        cyc(); smp();
        tests++; if (fetch_en !== 1'b1) begin fails++; $display("FAIL br_resp_req: got fe%b want 1", fetch_en); end
        cyc();
        branch_valid = 1'b1; branch_target = 8'h40;
        cyc();
        branch_valid = 1'b0;
        smp();
        tests++; if (instr_valid !== 1'b0 || fetch_address !== 16'h0040) begin
            fails++; $display("FAIL br_resp_flush: got v%b addr %h want v0 addr 0040", instr_valid, fetch_address); end
        wait_valid(e);
        tests++; if (e !== 2 || instr_pc !== 8'h40 || instr !== mem[8'h40]) begin
            fails++; $display("FAIL br_resp_target: got %h@%h after %0d want %h@40 after 2", instr, instr_pc, e, mem[8'h40]); end
    endtask

    task automatic test_branch_hold();
        int e;
        wait_valid(e);
        tests++; if (instr_pc !== 8'h41) begin fails++; $display("FAIL br_hold_setup: got pc %h want 41", instr_pc); end
        branch_valid = 1'b1; branch_target = 8'h40; instr_ready = 1'b1;
        cyc();
        branch_valid = 1'b0;
        smp();
        tests++; if (instr_valid !== 1'b0 || fetch_address !== 16'h0040) begin
            fails++; $display("FAIL br_hold_flush: got v%b addr %h want v0 addr 0040", instr_valid, fetch_address); end
        wait_valid(e);
        tests++; if (e !== 2 || instr_pc !== 8'h40 || instr !== mem[8'h40]) begin
            fails++; $display("FAIL br_hold_target: got %h@%h after %0d want %h@40 after 2", instr, instr_pc, e, mem[8'h40]); end
    endtask

    task automatic test_wrap();
        int e;
        branch_valid = 1'b1; branch_target = 8'hFF; instr_ready = 1'b1;
        cyc();
        branch_valid = 1'b0;
        smp();
        tests++; if (fetch_address !== 16'h00FF || fetch_en !== 1'b1) begin
            fails++; $display("FAIL wrap_addr_ff: got %h fe%b want 00ff fe1", fetch_address, fetch_en); end
        wait_valid(e);
        tests++; if (instr_pc !== 8'hFF || instr !== mem[8'hFF]) begin
            fails++; $display("FAIL wrap_ff: got %h@%h want %h@ff", instr, instr_pc, mem[8'hFF]); end
        cyc(); smp();
        tests++; if (fetch_address !== 16'h0000) begin fails++; $display("FAIL wrap_addr_00: got %h want 0000", fetch_address); end
        wait_valid(e);
        tests++; if (e !== 2 || instr_pc !== 8'h00 || instr !== mem[8'h00]) begin
            fails++; $display("FAIL wrap_00: got %h@%h after %0d want %h@00 after 2", instr, instr_pc, e, mem[8'h00]); end
    endtask

    task automatic test_mid_reset();
        int e;
        cyc(); cyc();
        rst = 1'b1;
        cyc(); smp();
        tests++; if (instr_valid !== 1'b0 || fetch_address !== 16'h0000 || fetch_en !== 1'b0) begin
            fails++; $display("FAIL midrst_state: got v%b addr %h fe%b want v0 addr 0000 fe0", instr_valid, fetch_address, fetch_en); end
        rst = 1'b0;
        wait_valid(e);
        tests++; if (e !== 3 || instr_pc !== 8'h00 || instr !== 32'hA000_0001) begin
            fails++; $display("FAIL midrst_restart: got %h@%h after %0d want a0000001@00 after 3", instr, instr_pc, e); end
    endtask

    task automatic test_random();
        logic [PC_W-1:0]    exp_pc;
        logic               exp_drop, exp_hold;
        logic [INSTR_W-1:0] h_instr;
        logic [PC_W-1:0]    h_pc;
        int                 idle_run;
        int                 rfails;
        rfails = fails;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b1; mem_busy = 1'b0; branch_valid = 1'b0; instr_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        smp();
        exp_pc = 8'h00; exp_drop = 1'b0; exp_hold = 1'b0; idle_run = 0;
        h_instr = '0; h_pc = '0;
        for (int c = 0; c < 3000 && (fails - rfails) < 10; c++) begin
            if (exp_drop) begin
                tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rnd_drop c%0d: got v%b want 0", c, instr_valid); end
            end
            if (exp_hold) begin
                tests++; if (instr_valid !== 1'b1 || instr !== h_instr || instr_pc !== h_pc) begin
                    fails++; $display("FAIL rnd_hold c%0d: got v%b %h@%h want v1 %h@%h", c, instr_valid, instr, instr_pc, h_instr, h_pc); end
            end
            if (instr_valid) begin
                tests++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
                    fails++; $display("FAIL rnd_word c%0d: got %h@%h want %h@%h", c, instr, instr_pc, mem[exp_pc], exp_pc); end
            end
            idle_run = (instr_valid || branch_valid) ? 0 : idle_run + 1;
            tests++; if (idle_run > 60) begin fails++; $display("FAIL rnd_liveness c%0d: got %0d idle cycles want <=60", c, idle_run); idle_run = 0; end
            mem_busy      = ($urandom_range(0, 2) == 0);
            instr_ready   = ($urandom_range(0, 3) != 0);
            branch_valid  = ($urandom_range(0, 15) == 0);
            branch_target = 8'($urandom);
            #1;
            tests++; if (fetch_en === 1'b1 && (mem_busy || instr_valid)) begin
                fails++; $display("FAIL rnd_fetch_en c%0d: got fe1 with busy%b valid%b want fe0", c, mem_busy, instr_valid); end
            exp_drop = branch_valid;
            exp_hold = !branch_valid && instr_valid && !instr_ready;
            h_instr  = mem[exp_pc];
            h_pc     = exp_pc;
            if (branch_valid) exp_pc = branch_target;
            else if (instr_valid && instr_ready) exp_pc = exp_pc + 8'd1;
            cyc(); smp();
        end
        branch_valid = 1'b0; mem_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_branch_resp();
        test_branch_hold();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
